// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter that funnels per-port cache line fills and writebacks onto one
// bus-engine command channel, with exactly one transaction in flight at a time.
//
// state | meaning
// IDLE  | no transaction; grants the round-robin winner as soon as any port requests
// ISSUE | presents the latched command until the bus engine accepts it
// WAIT  | waits for done_valid, bounded by TIMEOUT cycles
// RESP  | presents the response to the winning port until it consumes it
module mem_req_arbiter #(
    parameter int ADDR_WIDTH     = 64,
    parameter int LINE_WIDTH     = 512,
    parameter int REQUESTERS     = 4,
    parameter int LINE_BYTES_LOG = 6,
    parameter int TIMEOUT        = 1023
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [REQUESTERS-1:0]            req_valid,
    input  logic [REQUESTERS-1:0]            req_store,
    input  logic [REQUESTERS*ADDR_WIDTH-1:0] req_addr,
    input  logic [REQUESTERS*LINE_WIDTH-1:0] req_wdata,
    output logic [REQUESTERS-1:0]            req_grant,
    output logic [REQUESTERS-1:0]            resp_valid,
    input  logic [REQUESTERS-1:0]            resp_ready,
    output logic [LINE_WIDTH-1:0]            resp_data,
    output logic                             resp_stale,
    output logic                             resp_err,
    output logic                             cmd_valid,
    input  logic                             cmd_ready,
    output logic                             cmd_store,
    output logic [ADDR_WIDTH-1:0]            cmd_addr,
    output logic [LINE_WIDTH-1:0]            cmd_wdata,
    input  logic                             done_valid,
    input  logic [LINE_WIDTH-1:0]            done_data,
    input  logic                             inv_valid,
    input  logic [ADDR_WIDTH-1:0]            inv_addr
);
    localparam int ID_W  = $clog2(REQUESTERS);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                state;
    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       id_q;
    logic                  store_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic [LINE_WIDTH-1:0] data_q;
    logic                  stale_q;
    logic                  err_q;
    logic [CNT_W-1:0]      cnt_q;

    logic [ID_W-1:0]       winner;
    logic                  any_req;
    logic                  inv_hit;
    logic                  resp_done;
    logic                  unused_inv_offset;

    // First requesting port at or after rr_ptr, wrapping around.
    always_comb begin : pick
        int k;
        k       = 0;
        winner  = rr_ptr;
        any_req = 1'b0;
        for (int i = 0; i < REQUESTERS; i++) begin
            k = int'(rr_ptr) + i;
            if (k >= REQUESTERS) k = k - REQUESTERS;
            if (!any_req && req_valid[k]) begin
                any_req = 1'b1;
                winner  = ID_W'(k);
            end
        end
    end

    assign inv_hit   = inv_valid &&
                       (inv_addr[ADDR_WIDTH-1:LINE_BYTES_LOG] == addr_q[ADDR_WIDTH-1:LINE_BYTES_LOG]);
    assign resp_done = (state == RESP) && resp_ready[id_q];
    assign unused_inv_offset = ^inv_addr[LINE_BYTES_LOG-1:0];

    assign req_grant  = (state == IDLE && any_req) ? (REQUESTERS'(1) << winner) : '0;
    assign resp_valid = (state == RESP) ? (REQUESTERS'(1) << id_q) : '0;
    assign cmd_valid  = (state == ISSUE);
    assign cmd_store  = store_q;
    assign cmd_addr   = addr_q;
    assign cmd_wdata  = wdata_q;
    assign resp_data  = data_q;
    assign resp_stale = stale_q;
    assign resp_err   = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            id_q    <= '0;
            store_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            stale_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            // Stale marking runs in every busy state; the RESP exit clear below overrides it.
            if (state != IDLE && !store_q && inv_hit) stale_q <= 1'b1;

            case (state)
                IDLE: begin
                    if (any_req) begin
                        id_q    <= winner;
                        store_q <= req_store[winner];
                        addr_q  <= req_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
                        wdata_q <= req_wdata[winner*LINE_WIDTH +: LINE_WIDTH];
                        rr_ptr  <= (winner == ID_W'(REQUESTERS - 1)) ? '0 : winner + 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cmd_ready) begin
                        cnt_q <= '0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q != CNT_W'(TIMEOUT)) cnt_q <= cnt_q + 1'b1;
                    if (done_valid) begin
                        if (!store_q) data_q <= done_data;
                        state <= RESP;
                    end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                        err_q <= 1'b1;
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (resp_done) begin
                        stale_q <= 1'b0;
                        err_q   <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: a vector table of single-port transactions checked through
// a response scoreboard, plus round-robin and mid-transaction reset sequences.
module tb_mem_req_arbiter;
    localparam int AW = 64;
    localparam int LW = 512;
    localparam int NR = 4;
    localparam int TO = 7;

    logic             clk = 1'b0;
    logic             reset;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_store;
    logic [NR*AW-1:0] req_addr;
    logic [NR*LW-1:0] req_wdata;
    logic [NR-1:0]    req_grant;
    logic [NR-1:0]    resp_valid;
    logic [NR-1:0]    resp_ready;
    logic [LW-1:0]    resp_data;
    logic             resp_stale;
    logic             resp_err;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_store;
    logic [AW-1:0]    cmd_addr;
    logic [LW-1:0]    cmd_wdata;
    logic             done_valid;
    logic [LW-1:0]    done_data;
    logic             inv_valid;
    logic [AW-1:0]    inv_addr;

    always #5 clk = ~clk;

    mem_req_arbiter #(
        .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .REQUESTERS(NR), .LINE_BYTES_LOG(6), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_store(req_store), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_grant(req_grant), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_stale(resp_stale), .resp_err(resp_err),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_store(cmd_store),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .done_valid(done_valid), .done_data(done_data),
        .inv_valid(inv_valid), .inv_addr(inv_addr)
    );

    typedef struct {
        int          port;
        logic        store;
        logic [AW-1:0] addr;
        int          cmd_d;
        int          done_d;
        logic        inv_en;
        int          inv_c;
        logic [AW-1:0] inv_a;
        logic [7:0]  db;
        logic        e_stale;
        logic        e_err;
    } vec_t;

    typedef struct {
        logic [NR-1:0] valid;
        logic [LW-1:0] data;
        logic          chk_data;
        logic          stale;
        logic          err;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int   gq[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input int port, input logic store, input logic [AW-1:0] addr,
                                input int cmd_d, input int done_d, input logic inv_en,
                                input int inv_c, input logic [AW-1:0] inv_a, input logic [7:0] db,
                                input logic e_stale, input logic e_err);
        vec_t v;
        v.port = port; v.store = store; v.addr = addr; v.cmd_d = cmd_d; v.done_d = done_d;
        v.inv_en = inv_en; v.inv_c = inv_c; v.inv_a = inv_a; v.db = db;
        v.e_stale = e_stale; v.e_err = e_err;
        return v;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0; req_store = '0; req_addr = '0; req_wdata = '0; resp_ready = '0;
        cmd_ready = 1'b0; done_valid = 1'b0; done_data = '0; inv_valid = 1'b0; inv_addr = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic do_txn(input vec_t v);
        exp_t          e;
        logic [NR-1:0] oh;
        logic [LW-1:0] wd;
        int            lat;
        bit            got;
        oh = 4'b0001 << v.port;
        wd = v.store ? {8{v.addr}} : '0;
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW]  = 64'hDEAD_0000 + 64'(i);
            req_wdata[i*LW +: LW] = {16{32'hBAD0_0000 + 32'(i)}};
        end
        req_addr[v.port*AW +: AW]  = v.addr;
        req_wdata[v.port*LW +: LW] = wd;
        req_store = '0;
        req_store[v.port] = v.store;
        req_valid = oh;
        #1;
        chk("grant", req_grant, oh);
        e.valid    = oh;
        e.data     = {64{v.db}};
        e.chk_data = !v.store && !v.e_err;
        e.stale    = v.e_stale;
        e.err      = v.e_err;
        e.lat      = (v.done_d < 0 || v.done_d > TO) ? TO + 1 : v.done_d + 1;
        sb.push_back(e);
        tick();
        // Request inputs are scrambled once granted; the latched command must not move.
        req_valid = '0; req_store = '1; req_addr = '1; req_wdata = '1;
        #1;
        chk("cmd_valid", cmd_valid, 1);
        chk("cmd_store", cmd_store, v.store);
        chk("cmd_addr", cmd_addr, v.addr);
        chk("cmd_wdata", cmd_wdata, wd);
        for (int i = 0; i < v.cmd_d; i++) begin
            tick();
            chk("cmd_hold_valid", cmd_valid, 1);
            chk("cmd_hold_addr", cmd_addr, v.addr);
            chk("cmd_hold_wdata", cmd_wdata, wd);
        end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        got = 1'b0;
        lat = 0;
        for (int c = 0; c < 40; c++) begin
            if (resp_valid != '0) begin
                got = 1'b1;
                lat = c;
                break;
            end
            done_valid = (v.done_d >= 0 && c == v.done_d);
            done_data  = {64{v.db}};
            inv_valid  = v.inv_en && (c == v.inv_c);
            inv_addr   = v.inv_a;
            tick();
            done_valid = 1'b0;
            inv_valid  = 1'b0;
        end
        e = sb.pop_front();
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL resp_arrival: got no resp_valid in 40 cycles, required %b", e.valid);
        end else begin
            chk("resp_valid", resp_valid, e.valid);
            chk("resp_latency", lat, e.lat);
            chk("resp_stale", resp_stale, e.stale);
            chk("resp_err", resp_err, e.err);
            if (e.chk_data) chk("resp_data", resp_data, e.data);
            resp_ready = ~e.valid;
            tick();
            chk("resp_hold_valid", resp_valid, e.valid);
            chk("resp_hold_stale", resp_stale, e.stale);
            chk("resp_hold_err", resp_err, e.err);
            resp_ready = e.valid;
            tick();
            resp_ready = '0;
            chk("resp_release", resp_valid, 0);
        end
    endtask

    initial begin
        vec_t vecs[8];
        int   exp_g;
        vecs[0] = mk(2, 1'b0, 64'h1000, 0,  5, 1'b0, 0, 64'h0,    8'hAB, 1'b0, 1'b0);
        vecs[1] = mk(1, 1'b0, 64'h2040, 0,  4, 1'b1, 2, 64'h2078, 8'h11, 1'b1, 1'b0);
        vecs[2] = mk(1, 1'b0, 64'h2040, 0,  4, 1'b1, 2, 64'h2080, 8'h22, 1'b0, 1'b0);
        vecs[3] = mk(0, 1'b1, 64'h3000, 10, 3, 1'b0, 0, 64'h0,    8'h33, 1'b0, 1'b0);
        vecs[4] = mk(3, 1'b1, 64'h2040, 0,  3, 1'b1, 1, 64'h2040, 8'h44, 1'b0, 1'b0);
        vecs[5] = mk(0, 1'b0, 64'h4000, 0,  0, 1'b1, 0, 64'h4010, 8'h55, 1'b1, 1'b0);
        vecs[6] = mk(2, 1'b0, 64'h8000, 2, -1, 1'b0, 0, 64'h0,    8'h66, 1'b0, 1'b1);
        vecs[7] = mk(1, 1'b0, 64'h9000, 0,  7, 1'b0, 0, 64'h0,    8'h77, 1'b0, 1'b0);

        do_reset();
        chk("rst_grant", req_grant, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_stale", resp_stale, 0);
        chk("rst_err", resp_err, 0);
        chk("rst_data", resp_data, 0);
        chk("rst_cmd_addr", cmd_addr, 0);

        for (int i = 0; i < 8; i++) do_txn(vecs[i]);

        // All four ports request continuously from reset; engine and ports always ready.
        do_reset();
        for (int i = 0; i < NR; i++) begin
            gq.push_back(i);
            req_addr[i*AW +: AW] = 64'h7000 + 64'(i * 64);
        end
        req_valid = '1; cmd_ready = 1'b1; done_valid = 1'b1; resp_ready = '1;
        #1;
        for (int c = 0; c < 16; c++) begin
            if (req_grant != '0) begin
                if (gq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rr_extra_grant: got %b, required none", req_grant);
                end else begin
                    exp_g = gq.pop_front();
                    chk("rr_order", req_grant, 4'b0001 << exp_g);
                end
                chk("rr_grant_while_busy", cmd_valid || (resp_valid != '0), 0);
            end
            tick();
        end
        chk("rr_all_granted", gq.size(), 0);
        req_valid = '0; cmd_ready = 1'b0; done_valid = 1'b0; resp_ready = '0;

        // Reset while in WAIT with a pending stale mark, then a stray done in IDLE.
        do_reset();
        req_addr[1*AW +: AW] = 64'h5000;
        req_valid = 4'b0010;
        #1;
        chk("rstw_grant", req_grant, 4'b0010);
        tick();
        req_valid = '0;
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        inv_valid = 1'b1;
        inv_addr  = 64'h5000;
        tick();
        inv_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstw_grant_after", req_grant, 0);
        chk("rstw_resp_valid", resp_valid, 0);
        chk("rstw_cmd_valid", cmd_valid, 0);
        chk("rstw_stale", resp_stale, 0);
        chk("rstw_err", resp_err, 0);
        chk("rstw_data", resp_data, 0);
        done_valid = 1'b1;
        done_data  = {64{8'h5A}};
        tick();
        done_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("stray_done_resp", resp_valid, 0);
            chk("stray_done_cmd", cmd_valid, 0);
            tick();
        end
        do_txn(mk(3, 1'b0, 64'h6000, 0, 2, 1'b0, 0, 64'h0, 8'h3C, 1'b0, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
